// File: rtl/can_tx_data_sequencer.sv
// -----------------------------------------------------------------------------
// can_tx_data_sequencer
//
// Purpose:
//   Holds the four 16-bit CAN transmit data words (CPU word addresses 0x0e,
//   0x10, 0x12, 0x14). On a transmit request it streams min(dlc, 8) payload
//   bytes, most significant byte of word0 first, to the MAC/bit-stuffing stage
//   over a valid/ready byte handshake. CPU data writes are rejected while a
//   frame is in flight. Frame end is reported with a one-cycle done pulse,
//   together with err when the frame ended on a ready-stall timeout or abort.
//
// Optional feature macro:
//   CAN_TX_ABORT_EN - adds the tx_abort input and the abort path. Without it a
//                     frame ends only by completion or stall timeout.
//
// Parameters:
//   STALL_LIMIT - consecutive byte_valid=1/byte_ready=0 cycles before the
//                 frame is dropped with err; 0 disables the timeout.
//   CNT_W       - stall counter width; must be able to hold STALL_LIMIT.
//
// Ports:
//   clk         in   system clock, everything on the rising edge
//   rst         in   synchronous reset, active-high
//   cpu_we      in   CPU write strobe for a data word
//   cpu_sel     in   [1:0] word select: 0=0x0e, 1=0x10, 2=0x12, 3=0x14
//   cpu_wdata   in   [15:0] write data
//   dlc         in   [3:0] data length code, sampled with tx_req
//   tx_req      in   transmit request pulse (honoured in IDLE only)
//   tx_abort    in   abort request (CAN_TX_ABORT_EN builds only)
//   byte_data   out  [7:0] current payload byte (0 when not sending)
//   byte_valid  out  byte_data valid
//   byte_ready  in   consumer accepts byte
//   busy        out  frame in progress (SEND or DONE)
//   done        out  one-cycle end-of-frame pulse
//   err         out  one-cycle pulse coincident with done on timeout/abort
//   wr_blocked  out  one-cycle pulse: a CPU write was rejected last cycle
//   data_rd     out  [63:0] {word3, word2, word1, word0} readback
// -----------------------------------------------------------------------------
module can_tx_data_sequencer #(
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_sel,
    input  logic [15:0] cpu_wdata,
    input  logic [3:0]  dlc,
    input  logic        tx_req,
`ifdef CAN_TX_ABORT_EN
    input  logic        tx_abort,
`endif
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wr_blocked,
    output logic [63:0] data_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STALL_LIMIT_C = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;        // index of the byte on byte_data
    logic [3:0]        len_q, len_d;        // clamped byte count, 0..8
    logic [CNT_W-1:0]  stall_q, stall_d;    // consecutive not-ready cycles
    logic              err_flag_q, err_flag_d;
    logic              wr_blocked_q;
    logic [15:0]       words_q [4];

    // Decoded helpers
    logic              is_idle;
    logic              is_send;
    logic              is_done;
    logic [3:0]        dlc_clamped;
    logic [CNT_W-1:0]  stall_inc;
    logic              last_byte;
    logic              abort_req;
    logic [15:0]       cur_word;

    assign is_idle     = (state_q == ST_IDLE);
    assign is_send     = (state_q == ST_SEND);
    assign is_done     = (state_q == ST_DONE);
    assign dlc_clamped = (dlc > 4'd8) ? 4'd8 : dlc;
    assign stall_inc   = stall_q + CNT_ONE;
    assign last_byte   = ({1'b0, idx_q} == (len_q - 4'd1));

`ifdef CAN_TX_ABORT_EN
    assign abort_req = tx_abort;
`else
    assign abort_req = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Data word storage. Writes land only in IDLE, so the frame content is
    // frozen for the whole time busy is high. A write issued together with
    // tx_req commits at the same edge and is therefore part of the frame.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    words_q[gi] <= 16'h0000;
                end else if (is_idle && cpu_we && (cpu_sel == 2'(gi))) begin
                    words_q[gi] <= cpu_wdata;
                end
            end

            assign data_rd[gi*16 +: 16] = words_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            len_q        <= 4'd0;
            stall_q      <= '0;
            err_flag_q   <= 1'b0;
            wr_blocked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            stall_q      <= stall_d;
            err_flag_q   <= err_flag_d;
            // A write attempted while busy is dropped and flagged next cycle.
            wr_blocked_q <= cpu_we && !is_idle;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        stall_d    = stall_q;
        err_flag_d = err_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                stall_d    = '0;
                err_flag_d = 1'b0;
                if (tx_req) begin
                    len_d   = dlc_clamped;
                    idx_d   = 3'd0;
                    state_d = (dlc_clamped == 4'd0) ? ST_DONE : ST_SEND;
                end
            end

            ST_SEND: begin
                if (byte_ready) begin
                    stall_d = '0;
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    // Saturate so a disabled timeout never wraps the counter.
                    if (stall_q != CNT_MAX) begin
                        stall_d = stall_inc;
                    end
                    if ((STALL_LIMIT > 0) && (stall_inc == STALL_LIMIT_C)) begin
                        state_d    = ST_DONE;
                        err_flag_d = 1'b1;
                    end
                end

                // Abort wins over everything else in SEND; a byte accepted in
                // this same cycle has still been handed over (idx/stall above
                // are irrelevant once the frame is closing).
                if (abort_req) begin
                    state_d    = ST_DONE;
                    err_flag_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cur_word   = words_q[idx_q[2:1]];
    // Even index takes the high byte: word0 -> byte0=[15:8], byte1=[7:0].
    assign byte_data  = is_send ? (idx_q[0] ? cur_word[7:0] : cur_word[15:8])
                                : 8'h00;
    assign byte_valid = is_send;
    assign busy       = !is_idle;
    assign done       = is_done;
    assign err        = is_done && err_flag_q;
    assign wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_can_tx_data_sequencer.sv
module tb_can_tx_data_sequencer;

    localparam int STALL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [1:0]  cpu_sel;
    logic [15:0] cpu_wdata;
    logic [3:0]  dlc;
    logic        tx_req;
`ifdef CAN_TX_ABORT_EN
    logic        tx_abort;
`endif
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        wr_blocked;
    logic [63:0] data_rd;

    always #5 clk = ~clk;

    can_tx_data_sequencer #(.STALL_LIMIT(STALL), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_sel    (cpu_sel),
        .cpu_wdata  (cpu_wdata),
        .dlc        (dlc),
        .tx_req     (tx_req),
`ifdef CAN_TX_ABORT_EN
        .tx_abort   (tx_abort),
`endif
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr_blocked (wr_blocked),
        .data_rd    (data_rd)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected accepted bytes and expected err value per done pulse.
    logic [7:0] exp_bytes [$];
    bit         exp_err   [$];
    int         hs_count   = 0;
    int         done_count = 0;
    bit         hold_pending = 1'b0;
    logic [7:0] held_byte = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (byte_valid && hold_pending)
                check("stall_hold_byte", 64'(byte_data), 64'(held_byte));
            hold_pending = byte_valid && !byte_ready;
            held_byte    = byte_data;

            if (byte_valid && byte_ready) begin
                hs_count++;
                if (exp_bytes.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=0x%0h expected=none", byte_data);
                end else begin
                    logic [7:0] e;
                    e = exp_bytes.pop_front();
                    check("sb_byte", 64'(byte_data), 64'(e));
                end
            end

            if (done) begin
                done_count++;
                if (exp_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    bit e;
                    e = exp_err.pop_front();
                    check("sb_done_err", 64'(err), 64'(e));
                end
            end else if (err) begin
                checks++;
                failures++;
                $display("FAIL err_without_done actual=1 expected=0");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] sel, input logic [15:0] d);
        cpu_we    = 1'b1;
        cpu_sel   = sel;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic load_words();
        write_word(2'd0, 16'h1122);
        write_word(2'd1, 16'h3344);
        write_word(2'd2, 16'h5566);
        write_word(2'd3, 16'h7788);
    endtask

    // Expected payload byte k with the standard word pattern is 0x11*(k+1).
    task automatic push_frame(input int nbytes, input bit e_err);
        for (int k = 0; k < nbytes; k++)
            exp_bytes.push_back(8'(8'h11 * (k + 1)));
        exp_err.push_back(e_err);
    endtask

    task automatic start_frame(input logic [3:0] d);
        dlc    = d;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    // Runs until done is seen; n = rising edges since tx_req was sampled,
    // nv = cycles with byte_valid observed while waiting. Bounded.
    task automatic finish_frame(input bit toggle, input int start_n, output int n, output int nv);
        n  = start_n;
        nv = 0;
        while (!done && n < 60) begin
            if (byte_valid) nv++;
            tick();
            n++;
            if (toggle) byte_ready = ~byte_ready;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        tick();
        check("idle_after_done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nv, hs0, dc0;
        rst        = 1'b1;
        cpu_we     = 1'b0;
        cpu_sel    = 2'd0;
        cpu_wdata  = 16'h0;
        dlc        = 4'd0;
        tx_req     = 1'b0;
        byte_ready = 1'b1;
`ifdef CAN_TX_ABORT_EN
        tx_abort   = 1'b0;
`endif
        repeat (3) tick();
        check("rst_byte_valid", 64'(byte_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_byte_data", 64'(byte_data), 64'd0);
        check("rst_data_rd", data_rd, 64'd0);
        rst = 1'b0;
        tick();

        // Word writes and readback
        load_words();
        check("data_rd_after_writes", data_rd, 64'h7788_5566_3344_1122);
        check("idle_write_not_blocked", 64'(wr_blocked), 64'd0);

        // Full 8-byte frame, consumer always ready
        byte_ready = 1'b1;
        push_frame(8, 1'b0);
        start_frame(4'd8);
        finish_frame(1'b0, 1, n, nv);
        check("dlc8_done_edges", 64'(n), 64'd9);
        check("dlc8_valid_cycles", 64'(nv), 64'd8);

        // dlc=3 with byte_ready toggling
        hs0 = hs_count;
        push_frame(3, 1'b0);
        byte_ready = 1'b0;
        start_frame(4'd3);
        finish_frame(1'b1, 1, n, nv);
        check("dlc3_handshakes", 64'(hs_count - hs0), 64'd3);
        byte_ready = 1'b1;

        // dlc=0: straight to DONE, no bytes
        hs0 = hs_count;
        push_frame(0, 1'b0);
        start_frame(4'd0);
        finish_frame(1'b0, 1, n, nv);
        check("dlc0_done_edges", 64'(n), 64'd1);
        check("dlc0_no_valid", 64'(nv), 64'd0);
        check("dlc0_handshakes", 64'(hs_count - hs0), 64'd0);

        // dlc=12 clamps to 8
        push_frame(8, 1'b0);
        start_frame(4'd12);
        finish_frame(1'b0, 1, n, nv);
        check("dlc12_done_edges", 64'(n), 64'd9);
        check("dlc12_valid_cycles", 64'(nv), 64'd8);

        // CPU write during SEND is rejected
        push_frame(8, 1'b0);
        start_frame(4'd8);
        tick();
        cpu_we    = 1'b1;
        cpu_sel   = 2'd1;
        cpu_wdata = 16'hFFFF;
        tick();
        cpu_we    = 1'b0;
        check("busy_write_blocked_pulse", 64'(wr_blocked), 64'd1);
        check("busy_write_word1_kept", 64'(data_rd[31:16]), 64'h3344);
        tick();
        check("blocked_pulse_one_cycle", 64'(wr_blocked), 64'd0);
        finish_frame(1'b0, 4, n, nv);
        check("blocked_frame_done_edges", 64'(n), 64'd9);

        // Stall timeout: byte_ready held low
        push_frame(0, 1'b1);
        byte_ready = 1'b0;
        start_frame(4'd2);
        finish_frame(1'b0, 1, n, nv);
        check("stall_done_edges", 64'(n), 64'd5);
        check("stall_valid_cycles", 64'(nv), 64'd4);
        byte_ready = 1'b1;

        // Reset mid-SEND: silent drop
        dc0 = done_count;
        byte_ready = 1'b0;
        start_frame(4'd8);
        tick();
        check("pre_reset_in_send", 64'(byte_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_byte_valid", 64'(byte_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_byte_data", 64'(byte_data), 64'd0);
        check("midrst_data_rd", data_rd, 64'd0);
        rst = 1'b0;
        byte_ready = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", 64'(done_count - dc0), 64'd0);

        // Recovery after reset: reload and send a short frame
        load_words();
        push_frame(2, 1'b0);
        start_frame(4'd2);
        finish_frame(1'b0, 1, n, nv);
        check("recover_done_edges", 64'(n), 64'd3);

`ifdef CAN_TX_ABORT_EN
        // Abort after bytes 0x11 and 0x22 accepted
        push_frame(2, 1'b1);
        byte_ready = 1'b1;
        start_frame(4'd8);
        tick();
        tick();
        byte_ready = 1'b0;
        tx_abort   = 1'b1;
        tick();
        tx_abort   = 1'b0;
        check("abort_valid_dropped", 64'(byte_valid), 64'd0);
        check("abort_done", 64'(done), 64'd1);
        check("abort_err", 64'(err), 64'd1);
        tick();
        check("abort_idle_busy", 64'(busy), 64'd0);
        byte_ready = 1'b1;
        push_frame(1, 1'b0);
        start_frame(4'd1);
        finish_frame(1'b0, 1, n, nv);
        check("after_abort_done_edges", 64'(n), 64'd2);
`endif

        tick();
        check("sb_bytes_drained", 64'(exp_bytes.size()), 64'd0);
        check("sb_done_drained", 64'(exp_err.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
